// File: rtl/psad_accum_ctrl.sv
// psad_accum_ctrl: per-lane saturating partial-SAD accumulator with minimum-lane search.
// Collects ROWS_PER_BLOCK addend beats, finds the best lane, then holds the result until it is accepted.
module psad_accum_ctrl #(
    parameter int PIXELS_IN_BATCH  = 16,
    parameter int PSAD_BIT_DEPTH   = 14,
    parameter int ADDEND_BIT_DEPTH = 11,
    parameter int ROWS_PER_BLOCK   = 16
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         flush,
    input  logic                                         in_valid,
    output logic                                         in_ready,
    input  logic [PIXELS_IN_BATCH*ADDEND_BIT_DEPTH-1:0]  in_addend,
    output logic                                         out_valid,
    input  logic                                         out_ready,
    output logic [PIXELS_IN_BATCH*PSAD_BIT_DEPTH-1:0]    out_psad,
    output logic [PSAD_BIT_DEPTH-1:0]                    out_min_sad,
    output logic [$clog2(PIXELS_IN_BATCH)-1:0]           out_min_idx,
    output logic [PIXELS_IN_BATCH-1:0]                   out_sat
);
    localparam int N  = PIXELS_IN_BATCH;
    localparam int P  = PSAD_BIT_DEPTH;
    localparam int A  = ADDEND_BIT_DEPTH;
    localparam int R  = ROWS_PER_BLOCK;
    localparam int IW = $clog2(N);
    localparam int CW = $clog2(R + 1);

    typedef enum logic [1:0] {IDLE, ACCUM, MINSRCH, OUTPUT} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       row_cnt_q, row_cnt_d;
    logic [N-1:0][P-1:0] acc_q, acc_d;
    logic [N-1:0]        sat_q, sat_d;
    logic [P-1:0]        min_sad_q, min_sad_d;
    logic [IW-1:0]       min_idx_q, min_idx_d;
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;
    logic [N-1:0][P:0]   lane_sum;
    logic [P-1:0]        scan_sad;
    logic [IW-1:0]       scan_idx;
    logic                beat;

    assign beat        = in_valid & in_ready_q;
    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_psad    = acc_q;
    assign out_sat     = sat_q;
    assign out_min_sad = min_sad_q;
    assign out_min_idx = min_idx_q;

    // One extra bit of headroom is enough: acc <= 2^P-1 and addend < 2^(P-1).
    always_comb begin
        for (int i = 0; i < N; i++)
            lane_sum[i] = {1'b0, acc_q[i]} + (P+1)'(in_addend[i*A +: A]);
    end

    // Strict less-than while scanning upward keeps the lowest index on ties.
    always_comb begin
        scan_sad = acc_q[0];
        scan_idx = '0;
        for (int i = 1; i < N; i++) begin
            if (acc_q[i] < scan_sad) begin
                scan_sad = acc_q[i];
                scan_idx = IW'(i);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        row_cnt_d = row_cnt_q;
        acc_d     = acc_q;
        sat_d     = sat_q;
        min_sad_d = min_sad_q;
        min_idx_d = min_idx_q;
        case (state_q)
            IDLE: begin
                if (beat) begin
                    for (int i = 0; i < N; i++)
                        acc_d[i] = P'(in_addend[i*A +: A]);
                    sat_d     = '0;
                    row_cnt_d = CW'(1);
                    state_d   = (R == 1) ? MINSRCH : ACCUM;
                end
            end
            ACCUM: begin
                if (beat) begin
                    for (int i = 0; i < N; i++) begin
                        acc_d[i] = lane_sum[i][P] ? {P{1'b1}} : lane_sum[i][P-1:0];
                        sat_d[i] = sat_q[i] | lane_sum[i][P];
                    end
                    row_cnt_d = row_cnt_q + CW'(1);
                    state_d   = (row_cnt_q == CW'(R - 1)) ? MINSRCH : ACCUM;
                end
            end
            MINSRCH: begin
                min_sad_d = scan_sad;
                min_idx_d = scan_idx;
                state_d   = OUTPUT;
            end
            default: begin
                if (out_ready) begin
                    state_d   = IDLE;
                    row_cnt_d = '0;
                end
            end
        endcase
        if (flush) begin
            state_d   = IDLE;
            row_cnt_d = '0;
        end
        in_ready_d  = (state_d == IDLE) || (state_d == ACCUM);
        out_valid_d = (state_d == OUTPUT);
    end

    // Handshake flags are registered from the next state so in_ready stays low through reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            row_cnt_q   <= '0;
            acc_q       <= '0;
            sat_q       <= '0;
            min_sad_q   <= '0;
            min_idx_q   <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_cnt_q   <= row_cnt_d;
            acc_q       <= acc_d;
            sat_q       <= sat_d;
            min_sad_q   <= min_sad_d;
            min_idx_q   <= min_idx_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end
endmodule

// File: tb/tb_psad_accum_ctrl.sv
// tb_psad_accum_ctrl: directed and randomized blocks checked against an arithmetic model of the block SAD
module tb_psad_accum_ctrl;
  localparam int N    = 16;
  localparam int P    = 14;
  localparam int A    = 11;
  localparam int R    = 9;
  localparam int IW   = $clog2(N);
  localparam int MAXI = (1 << P) - 1;
  logic              clk = 1'b0;
  logic              rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [N*A-1:0]    in_addend;
  logic [N*P-1:0]    out_psad;
  logic [P-1:0]      out_min_sad;
  logic [IW-1:0]     out_min_idx;
  logic [N-1:0]      out_sat;
  int                n_chk = 0;
  int                n_fail = 0;
  logic [N*A-1:0]    beats [R];
  logic [P-1:0]      exp_psad [N];
  logic [N-1:0]      exp_sat;
  logic [P-1:0]      exp_min;
  logic [IW-1:0]     exp_idx;
  logic              seen;
  always #5 clk = ~clk;
  psad_accum_ctrl #(
    .PIXELS_IN_BATCH(N), .PSAD_BIT_DEPTH(P), .ADDEND_BIT_DEPTH(A), .ROWS_PER_BLOCK(R)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_addend(in_addend), .out_valid(out_valid), .out_ready(out_ready), .out_psad(out_psad),
    .out_min_sad(out_min_sad), .out_min_idx(out_min_idx), .out_sat(out_sat)
  );
  task automatic chk(input string tag, input logic [N*P-1:0] obs, input logic [N*P-1:0] e);
    n_chk++;
    if (obs !== e) begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, e);
    end
  endtask
  task automatic model();
    int m;
    for (int i = 0; i < N; i++) begin
      int tot;
      tot = 0;
      for (int r = 0; r < R; r++) tot += int'(beats[r][i*A +: A]);
      exp_sat[i]  = (tot > MAXI);
      exp_psad[i] = P'((tot > MAXI) ? MAXI : tot);
    end
    m = MAXI + 1;
    for (int i = 0; i < N; i++) if (int'(exp_psad[i]) < m) m = int'(exp_psad[i]);
    exp_min = P'(m);
    exp_idx = '0;
    for (int i = N - 1; i >= 0; i--) if (int'(exp_psad[i]) == m) exp_idx = IW'(i);
  endtask
  task automatic fill_rand(input int lo, input int hi);
    for (int r = 0; r < R; r++)
      for (int i = 0; i < N; i++) beats[r][i*A +: A] = A'($urandom_range(hi, lo));
  endtask
  task automatic fill_lane(input int base, input int mul);
    for (int r = 0; r < R; r++)
      for (int i = 0; i < N; i++) beats[r][i*A +: A] = A'(base + mul * i);
  endtask
  task automatic drive_beat(input logic [N*A-1:0] a);
    int k;
    k = 0;
    in_valid  = 1'b1;
    in_addend = a;
    while (!in_ready && k < 50) begin @(negedge clk); k++; end
    chk("beat_accept_timeout", (k < 50), 1'b1);
    @(negedge clk);
    in_valid  = 1'b0;
    in_addend = 'x;
  endtask
  task automatic drive_all(input int gap);
    for (int r = 0; r < R; r++) begin
      repeat ($urandom_range(gap, 0)) @(negedge clk);
      drive_beat(beats[r]);
    end
  endtask
  task automatic check_out(input string tag);
    chk($sformatf("%s:valid_t1", tag), out_valid, 1'b0);
    chk($sformatf("%s:ready_t1", tag), in_ready, 1'b0);
    @(negedge clk);
    chk($sformatf("%s:valid_t2", tag), out_valid, 1'b1);
    chk($sformatf("%s:ready_out", tag), in_ready, 1'b0);
    for (int i = 0; i < N; i++)
      chk($sformatf("%s:psad%0d", tag, i), out_psad[i*P +: P], exp_psad[i]);
    chk($sformatf("%s:sat", tag), out_sat, exp_sat);
    chk($sformatf("%s:min_sad", tag), out_min_sad, exp_min);
    chk($sformatf("%s:min_idx", tag), out_min_idx, exp_idx);
  endtask
  task automatic accept(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk($sformatf("%s:valid_after_accept", tag), out_valid, 1'b0);
    chk($sformatf("%s:ready_after_accept", tag), in_ready, 1'b1);
  endtask
  task automatic run_block(input string tag, input int gap);
    model();
    drive_all(gap);
    check_out(tag);
    accept(tag);
  endtask
  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_addend = '0;
    repeat (2) @(negedge clk);
    chk("rst:in_ready", in_ready, 1'b0);
    chk("rst:out_valid", out_valid, 1'b0);
    chk("rst:psad", out_psad, {(N*P){1'b0}});
    chk("rst:min_sad", out_min_sad, {P{1'b0}});
    chk("rst:min_idx", out_min_idx, {IW{1'b0}});
    chk("rst:sat", out_sat, {N{1'b0}});
    rst_n = 1'b1;
    fill_lane(1, 1);
    run_block("T1", 0);
    fill_lane(2047, 0);
    model();
    drive_all(0);
    check_out("T2");
    flush = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0; out_ready = 1'b0;
    chk("T2:flush_out_valid", out_valid, 1'b0);
    chk("T2:flush_in_ready", in_ready, 1'b1);
    fill_rand(20, 200);
    for (int r = 0; r < R; r++) begin
      beats[r][5*A +: A] = A'((r == 0) ? 100 : 0);
      beats[r][9*A +: A] = A'((r == 0) ? 100 : 0);
    end
    run_block("T3", 1);
    chk("T3:tie_idx_model", exp_idx, IW'(5));
    fill_rand(0, 2047);
    model();
    drive_all(0);
    check_out("T4");
    for (int k = 0; k < 10; k++) begin
      in_valid  = 1'b1;
      in_addend = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      chk($sformatf("T4:hold%0d_valid", k), out_valid, 1'b1);
      chk($sformatf("T4:hold%0d_ready", k), in_ready, 1'b0);
      chk($sformatf("T4:hold%0d_psad", k), out_psad[(k%N)*P +: P], exp_psad[k%N]);
      chk($sformatf("T4:hold%0d_min", k), out_min_sad, exp_min);
      chk($sformatf("T4:hold%0d_sat", k), out_sat, exp_sat);
    end
    in_valid = 1'b0;
    in_addend = 'x;
    accept("T4");
    fill_rand(0, 600);
    run_block("T4b", 0);
    fill_rand(0, 2047);
    drive_beat(beats[0]);
    drive_beat(beats[1]);
    flush = 1'b1; in_valid = 1'b1; in_addend = beats[2];
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; in_addend = 'x;
    chk("T5:flush_ready", in_ready, 1'b1);
    seen = 1'b0;
    repeat (R + 3) begin @(negedge clk); seen = seen | out_valid; end
    chk("T5:no_out_valid", seen, 1'b0);
    fill_lane(1, 0);
    run_block("T5", 0);
    fill_rand(100, 2047);
    drive_beat(beats[0]);
    drive_beat(beats[1]);
    drive_beat(beats[2]);
    #2 rst_n = 1'b0;
    #1;
    chk("T6:rst_psad", out_psad, {(N*P){1'b0}});
    chk("T6:rst_ready", in_ready, 1'b0);
    chk("T6:rst_valid", out_valid, 1'b0);
    chk("T6:rst_min", out_min_sad, {P{1'b0}});
    @(negedge clk);
    rst_n = 1'b1;
    fill_rand(0, 2047);
    run_block("T6", 3);
    for (int k = 0; k < 6; k++) begin
      case (k % 3)
        0: fill_rand(0, 300);
        1: fill_rand(0, 2047);
        default: fill_rand(1500, 2047);
      endcase
      run_block($sformatf("RND%0d", k), k % 3);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
